regfile_scoreboard: RTL

//  Parametrised integer register file with N read ports and one write port.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/regfile_scoreboard.sv | 77 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register file with pending-write scoreboard.
// Holds the default geometry, the index/word types and the hardwired-zero index.
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [RF_DATA_WIDTH-1:0] reg_word_t;

    // Index 0 reads as zero and can never be written or marked pending.
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one pending bit per architectural register plus
// a registered count of pending registers.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   iss_en, iss_addr  an issued instruction will write iss_addr (marks pending)
//   wr_en, wr_addr    writeback to wr_addr (clears pending)
//   flush             drops every pending mark; beats a same-cycle issue
//   pending           pending vector, bit 0 always 0
//   pending_cnt       popcount of pending
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_en,
    input  logic [ADDR_WIDTH-1:0]      iss_addr,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic                       flush,
    output logic [(2**ADDR_WIDTH)-1:0] pending,
    output logic [ADDR_WIDTH:0]        pending_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic             set_ok;
    logic             clr_ok;
    logic             inc;
    logic             dec;
    logic [DEPTH-1:0] pend_nxt;
    logic [ADDR_WIDTH:0] cnt_nxt;

    always_comb begin
        set_ok   = iss_en && (iss_addr != ZERO) && !flush;
        clr_ok   = wr_en && (wr_addr != ZERO);
        pend_nxt = pending;
        // Clear first, then set: on a same-index collision the younger
        // producer (the issue) leaves the register pending.
        if (clr_ok) pend_nxt[wr_addr]  = 1'b0;
        if (set_ok) pend_nxt[iss_addr] = 1'b1;
        if (flush)  pend_nxt           = '0;
        pend_nxt[0] = 1'b0;

        // Count tracks only real transitions of the vector, so it stays
        // equal to the popcount without an adder tree.
        inc = set_ok && !pending[iss_addr];
        dec = clr_ok && pending[wr_addr] && !(set_ok && (iss_addr == wr_addr));
        if (flush)
            cnt_nxt = '0;
        else
            cnt_nxt = pending_cnt + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pend_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file: NUM_RD combinational read ports, one write port,
// optional write-to-read bypass, and a per-register pending scoreboard used
// by the hazard unit (rd_busy) to stall on outstanding writebacks.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rd_addr / rd_data   packed per-port read index / data
//   rd_busy             per-port: source register awaiting writeback
//   wr_en/addr/data     writeback port
//   iss_en/iss_addr     destination of a newly issued instruction
//   flush               drop all pending marks
//   pending_cnt         number of pending registers
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    input  logic                         flush,
    output logic [ADDR_WIDTH:0]          pending_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic                  wr_ok;

    assign wr_ok = wr_en && (wr_addr != ZERO);

    // regs[0] is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .flush       (flush),
        .pending     (pending),
        .pending_cnt (pending_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        assign ra  = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        // Forwarding a writeback also reports not-busy, since that write is
        // the one the reader was waiting for.
        assign hit = (BYPASS != 0) && wr_ok && (wr_addr == ra);
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = hit ? wr_data : regs[ra];
        assign rd_busy[i] = hit ? 1'b0 : pending[ra];
    end

endmodule
